// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM skid stage: beat payload, occupancy states,
// and the forwarding-eligibility helper.
package ex_mem_pkg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;
  localparam int ZR_IDX = 31;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] store_data;
  } ex_beat_t;

  // XZR is architecturally zero, so a write to it must never be forwarded.
  function automatic logic fwd_enable(input logic valid, input logic reg_write,
                                      input logic [REG_W-1:0] rd);
    return valid & reg_write & (rd != REG_W'(ZR_IDX));
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-entry valid/ready skid buffer. in_ready_o is a flop so the
// upstream handshake never sees a combinational path from out_ready_i.
module pipe_skid_reg
  import ex_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  occ_e         occ_q, occ_d, occ_s;
  logic [W-1:0] head_q, head_d, head_s;
  logic [W-1:0] skid_q, skid_d, skid_s;
  logic         ready_q, valid_q;
  logic         accept_s, retire_s;

  assign accept_s = in_valid_i & ready_q;
  assign retire_s = valid_q & out_ready_i;

  // Occupancy and storage next state; flush drops everything not yet retired.
  always_comb begin
    occ_s  = occ_q;
    head_s = head_q;
    skid_s = skid_q;
    case (occ_q)
      EMPTY: begin
        if (accept_s) begin
          occ_s  = ONE;
          head_s = in_data_i;
        end else begin
          occ_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && !retire_s) begin
          occ_s  = FULL;
          skid_s = in_data_i;
        end else if (accept_s && retire_s) begin
          occ_s  = ONE;
          head_s = in_data_i;
        end else if (retire_s) begin
          occ_s = EMPTY;
        end else begin
          occ_s = ONE;
        end
      end
      FULL: begin
        if (retire_s) begin
          occ_s  = ONE;
          head_s = skid_q;
        end else begin
          occ_s = FULL;
        end
      end
      default: begin
        occ_s = EMPTY;
      end
    endcase

    if (flush_i) begin
      occ_d  = EMPTY;
      head_d = head_q;
      skid_d = skid_q;
    end else begin
      occ_d  = occ_s;
      head_d = head_s;
      skid_d = skid_s;
    end
  end

  // State, payload and handshake flops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occ_q   <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= (occ_d != FULL);
      valid_q <= (occ_d != EMPTY);
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = head_q;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage: elastic two-entry buffer of ALU beats, CBZ
// resolution with a registered taken pulse, and a head-of-stage forward tap.
module ex_mem_skid_stage
  import ex_mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic              ex_zero_i,
  input  logic [REG_W-1:0]  ex_rd_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_mem_write_i,
  input  logic [DATA_W-1:0] ex_store_data_i,
  input  logic              ex_cbz_i,
  input  logic [DATA_W-1:0] ex_br_target_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [DATA_W-1:0] mem_result_o,
  output logic              mem_zero_o,
  output logic [REG_W-1:0]  mem_rd_o,
  output logic              mem_reg_write_o,
  output logic              mem_mem_read_o,
  output logic              mem_mem_write_o,
  output logic [DATA_W-1:0] mem_store_data_o,
  output logic              br_taken_o,
  output logic [DATA_W-1:0] br_target_o,
  output logic              fwd_valid_o,
  output logic [REG_W-1:0]  fwd_rd_o,
  output logic [DATA_W-1:0] fwd_value_o
);

  ex_beat_t          beat_in_s, head_s;
  logic              accept_s;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_target_q, br_target_d;

  assign beat_in_s = '{result:     ex_result_i,
                       zero:       ex_zero_i,
                       rd:         ex_rd_i,
                       reg_write:  ex_reg_write_i,
                       mem_read:   ex_mem_read_i,
                       mem_write:  ex_mem_write_i,
                       store_data: ex_store_data_i};

  pipe_skid_reg #(
    .W($bits(ex_beat_t))
  ) u_skid (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .in_valid_i  (ex_valid_i),
    .in_ready_o  (ex_ready_o),
    .in_data_i   (beat_in_s),
    .out_valid_o (mem_valid_o),
    .out_ready_i (mem_ready_i),
    .out_data_o  (head_s)
  );

  assign accept_s = ex_valid_i & ex_ready_o;

  // CBZ taken when the accepted beat's zero flag is set; a flushed beat never branches.
  always_comb begin
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;
    if (accept_s && ex_cbz_i && ex_zero_i && !flush_i) begin
      br_taken_d  = 1'b1;
      br_target_d = ex_br_target_i;
    end else begin
      br_taken_d = 1'b0;
    end
  end

  // Branch pulse and target flops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  assign br_taken_o       = br_taken_q;
  assign br_target_o      = br_target_q;
  assign mem_result_o     = head_s.result;
  assign mem_zero_o       = head_s.zero;
  assign mem_rd_o         = head_s.rd;
  assign mem_reg_write_o  = head_s.reg_write;
  assign mem_mem_read_o   = head_s.mem_read;
  assign mem_mem_write_o  = head_s.mem_write;
  assign mem_store_data_o = head_s.store_data;

  assign fwd_valid_o = fwd_enable(mem_valid_o, head_s.reg_write, head_s.rd);
  assign fwd_rd_o    = head_s.rd;
  assign fwd_value_o = head_s.result;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Table-driven bench for ex_mem_skid_stage: each row is one cycle of inputs
// plus the outputs expected during that cycle, before its rising edge.
module tb_ex_mem_skid_stage;

  localparam logic [63:0] SD_XOR = 64'hA5A5_0000_FFFF_0000;

  logic        clk = 1'b0;
  logic        reset, flush, ex_valid, ex_ready, ex_zero, ex_reg_write;
  logic        ex_mem_read, ex_mem_write, ex_cbz;
  logic [63:0] ex_result, ex_store_data, ex_br_target;
  logic [4:0]  ex_rd;
  logic        mem_valid, mem_ready, mem_zero, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [63:0] mem_result, mem_store_data, br_target, fwd_value;
  logic [4:0]  mem_rd, fwd_rd;
  logic        br_taken, fwd_valid;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_mem_skid_stage dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_result_i(ex_result), .ex_zero_i(ex_zero), .ex_rd_i(ex_rd),
    .ex_reg_write_i(ex_reg_write), .ex_mem_read_i(ex_mem_read),
    .ex_mem_write_i(ex_mem_write), .ex_store_data_i(ex_store_data),
    .ex_cbz_i(ex_cbz), .ex_br_target_i(ex_br_target),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_result_o(mem_result), .mem_zero_o(mem_zero), .mem_rd_o(mem_rd),
    .mem_reg_write_o(mem_reg_write), .mem_mem_read_o(mem_mem_read),
    .mem_mem_write_o(mem_mem_write), .mem_store_data_o(mem_store_data),
    .br_taken_o(br_taken), .br_target_o(br_target),
    .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_value_o(fwd_value)
  );

  typedef struct {
    logic        chk, rst, fl, v;
    logic [63:0] res;
    logic        zero;
    logic [4:0]  rd;
    logic        rw, cbz;
    logic [63:0] tgt;
    logic        mr;
    logic        e_rdy, e_mv;
    logic [63:0] e_res;
    logic [4:0]  e_rd;
    logic        e_bt;
    logic [63:0] e_tgt;
    logic        e_fv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic chk, rst, fl, v, input logic [63:0] res,
                              input logic zero, input logic [4:0] rd, input logic rw, cbz,
                              input logic [63:0] tgt, input logic mr, e_rdy, e_mv,
                              input logic [63:0] e_res, input logic [4:0] e_rd,
                              input logic e_bt, input logic [63:0] e_tgt, input logic e_fv);
    vec_t x;
    x.chk = chk; x.rst = rst; x.fl = fl; x.v = v; x.res = res; x.zero = zero;
    x.rd = rd; x.rw = rw; x.cbz = cbz; x.tgt = tgt; x.mr = mr;
    x.e_rdy = e_rdy; x.e_mv = e_mv; x.e_res = e_res; x.e_rd = e_rd;
    x.e_bt = e_bt; x.e_tgt = e_tgt; x.e_fv = e_fv;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    reset = x.rst; flush = x.fl; ex_valid = x.v; ex_result = x.res; ex_zero = x.zero;
    ex_rd = x.rd; ex_reg_write = x.rw; ex_cbz = x.cbz; ex_br_target = x.tgt;
    ex_mem_read = x.res[0]; ex_mem_write = x.res[1]; ex_store_data = x.res ^ SD_XOR;
    mem_ready = x.mr;
  endtask

  task automatic check_row(input vec_t x, input int idx);
    bit bad;
    bad = (ex_ready !== x.e_rdy) || (mem_valid !== x.e_mv) ||
          (br_taken !== x.e_bt) || (fwd_valid !== x.e_fv);
    if (x.e_mv)
      bad = bad || (mem_result !== x.e_res) || (mem_rd !== x.e_rd) ||
            (mem_store_data !== (x.e_res ^ SD_XOR)) ||
            (mem_mem_read !== x.e_res[0]) || (mem_mem_write !== x.e_res[1]);
    if (x.e_bt) bad = bad || (br_target !== x.e_tgt);
    if (x.e_fv) bad = bad || (fwd_rd !== x.e_rd) || (fwd_value !== x.e_res);
    applied++;
    if (bad) begin
      miscompares++;
      $display("FAIL vec%0d: got rdy=%b mv=%b res=%h rd=%0d bt=%b tgt=%h fv=%b frd=%0d fval=%h; want rdy=%b mv=%b res=%h rd=%0d bt=%b tgt=%h fv=%b",
               idx, ex_ready, mem_valid, mem_result, mem_rd, br_taken, br_target, fwd_valid,
               fwd_rd, fwd_value, x.e_rdy, x.e_mv, x.e_res, x.e_rd, x.e_bt, x.e_tgt, x.e_fv);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_result = 64'h0; ex_zero = 1'b0;
    ex_rd = 5'd0; ex_reg_write = 1'b0; ex_cbz = 1'b0; ex_br_target = 64'h0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_store_data = 64'h0; mem_ready = 1'b0;

    //          chk  rst  fl   v    res       z    rd    rw   cbz  tgt       mr   rdy  mv   e_res     e_rd  bt   e_tgt     fv
    // reset held with ex_valid, then first beat
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b1,64'h99,  1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b0,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,64'h99,  1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'h1234,1'b0,5'd3, 1'b1,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b1,1'b1,1'b1,64'h1234,5'd3, 1'b0,64'h0,   1'b1));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    // back-pressure: A, B fill the stage, C waits for space
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'hA,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'hB,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b1,64'hA,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'hC,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b0,1'b1,64'hA,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'hC,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b1,1'b0,1'b1,64'hA,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'hC,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b1,1'b1,1'b1,64'hB,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b1,1'b1,1'b1,64'hC,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    // streaming: accept and retire every cycle
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'h100 + 64'(k),1'b0,5'd0,1'b0,1'b0,64'h0,1'b1,1'b1,
                        (k != 0),64'h100 + 64'(k) - 64'h1,5'd0,1'b0,64'h0,1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b1,1'b1,1'b1,64'h107, 5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    // CBZ taken, then not taken
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'h50,  1'b1,5'd0, 1'b0,1'b1,64'h400, 1'b1,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b1,1'b1,1'b1,64'h50,  5'd0, 1'b1,64'h400, 1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'h51,  1'b0,5'd0, 1'b0,1'b1,64'h800, 1'b1,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b1,1'b1,1'b1,64'h51,  5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    // flush from FULL, flush of an accepted CBZ beat, flush with retire
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'h60,  1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'h61,  1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b1,64'h60,  5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b1,64'h62,  1'b1,5'd0, 1'b0,1'b1,64'hBAD, 1'b0,1'b0,1'b1,64'h60,  5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b1,64'h63,  1'b1,5'd0, 1'b0,1'b1,64'hBAD, 1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'h64,  1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b1,1'b1,1'b1,64'h64,  5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    // forwarding tap: XZR suppressed, rd=5 visible while MEM stalls
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'h70,  1'b0,5'd31,1'b1,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'hFFFF,1'b0,5'd5, 1'b1,1'b0,64'h0,   1'b0,1'b1,1'b1,64'h70,  5'd31,1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b0,1'b1,64'h70,  5'd31,1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b1,1'b0,1'b1,64'h70,  5'd31,1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b1,64'hFFFF,5'd5, 1'b0,64'h0,   1'b1));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b1,64'hFFFF,5'd5, 1'b0,64'h0,   1'b1));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b1,1'b1,1'b1,64'hFFFF,5'd5, 1'b0,64'h0,   1'b1));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    // back-to-back CBZ pulses, then reset (with flush) mid-operation
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'h80,  1'b1,5'd0, 1'b0,1'b1,64'h123, 1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,64'h81,  1'b1,5'd0, 1'b0,1'b1,64'h456, 1'b0,1'b1,1'b1,64'h80,  5'd0, 1'b1,64'h123, 1'b0));
    vecs.push_back(mk(1'b1,1'b1,1'b1,1'b1,64'h82,  1'b1,5'd0, 1'b0,1'b1,64'h789, 1'b0,1'b0,1'b1,64'h80,  5'd0, 1'b1,64'h456, 1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0,   1'b0,5'd0, 1'b0,1'b0,64'h0,   1'b0,1'b1,1'b0,64'h0,   5'd0, 1'b0,64'h0,   1'b0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      if (vecs[i].chk) check_row(vecs[i], i);
    end

    // Load a full-featured beat, then reset must clear every payload field.
    @(negedge clk);
    drive(mk(1'b0,1'b0,1'b0,1'b1,64'hDEAD,1'b1,5'd7,1'b1,1'b1,64'h999,1'b0,
             1'b0,1'b0,64'h0,5'd0,1'b0,64'h0,1'b0));
    @(negedge clk);
    ex_valid = 1'b0;
    reset = 1'b1;
    applied++;
    if (!(mem_valid === 1'b1 && mem_result === 64'hDEAD && mem_rd === 5'd7 &&
          br_taken === 1'b1 && br_target === 64'h999 && fwd_valid === 1'b1)) begin
      miscompares++;
      $display("FAIL preload: got mv=%b res=%h rd=%0d bt=%b tgt=%h fv=%b; want mv=1 res=dead rd=7 bt=1 tgt=999 fv=1",
               mem_valid, mem_result, mem_rd, br_taken, br_target, fwd_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    applied++;
    if (!(ex_ready === 1'b1 && mem_valid === 1'b0 && br_taken === 1'b0 && fwd_valid === 1'b0 &&
          mem_result === 64'h0 && mem_rd === 5'd0 && mem_store_data === 64'h0 &&
          br_target === 64'h0 && mem_zero === 1'b0 && mem_reg_write === 1'b0 &&
          mem_mem_read === 1'b0 && mem_mem_write === 1'b0)) begin
      miscompares++;
      $display("FAIL rst_clear: got rdy=%b mv=%b bt=%b fv=%b res=%h rd=%0d sd=%h tgt=%h z=%b rw=%b mrd=%b mwr=%b; want rdy=1 all others 0",
               ex_ready, mem_valid, br_taken, fwd_valid, mem_result, mem_rd, mem_store_data,
               br_target, mem_zero, mem_reg_write, mem_mem_read, mem_mem_write);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
